// File: rtl/i2c_apb_master_if.sv
// Command/response and APB signal bundle for i2c_apb_master.
// The master modport is the design's view; the slave modport is the host/APB-target side.
interface i2c_apb_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [DATA_WIDTH-1:0] cmd_wdata_i;
    logic                  rsp_valid_o;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_error_o;
    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [ADDR_WIDTH-1:0] paddr_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pready_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, prdata_i, pready_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
               psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, prdata_i, pready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
               psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );
endinterface

// File: rtl/i2c_apb_master.sv
// APB initiator: runs one SETUP/ACCESS transfer per accepted command and returns a response strobe.
// Optional ACCESS wait-state timeout enabled by defining I2C_APB_MASTER_TIMEOUT_EN.
module i2c_apb_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               pclk_i,
    input  logic               preset_n_i,
    i2c_apb_master_if.master   bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state_q,     state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  pwrite_q,    pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef I2C_APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_error_q, rsp_error_d;
`endif

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef I2C_APB_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            rsp_error_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef I2C_APB_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            rsp_error_q <= rsp_error_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef I2C_APB_MASTER_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        rsp_error_d = rsp_error_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i && cmd_ready_q) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = bus.cmd_write_i;
                    paddr_d   = bus.cmd_addr_i;
                    pwdata_d  = bus.cmd_wdata_i;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef I2C_APB_MASTER_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ACCESS: begin
                // A ready target always wins, even on the cycle the wait limit would be hit.
                if (bus.pready_i) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata_i;
`ifdef I2C_APB_MASTER_TIMEOUT_EN
                    rsp_error_d = 1'b0;
                end else if (tmo_cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                end else begin
                    tmo_cnt_d   = tmo_cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.psel_o      = psel_q;
    assign bus.penable_o   = penable_q;
    assign bus.pwrite_o    = pwrite_q;
    assign bus.paddr_o     = paddr_q;
    assign bus.pwdata_o    = pwdata_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
`ifdef I2C_APB_MASTER_TIMEOUT_EN
    assign bus.rsp_error_o = rsp_error_q;
`else
    assign bus.rsp_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_apb_master.sv
// Scoreboard bench for i2c_apb_master: randomized commands against a register-file
// reference model, with an APB target model inserting queued wait states.
module tb_i2c_apb_master;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int TMO = 16;
`ifdef I2C_APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t             exp_q[$];
    logic [16:0]      apb_q[$];
    int               ws_q[$];
    logic [DW-1:0]    ref_mem[256];
    logic [DW-1:0]    slave_mem[256];

    i2c_apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    i2c_apb_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk_i(clk),
        .preset_n_i(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Issue one command; expectation is derived from register-file semantics.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int ws, input bit exp_rsp);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = w;
        bus.cmd_addr_i  = a;
        bus.cmd_wdata_i = d;
        while (!bus.cmd_ready_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            chk("accept_timeout", 32'd1, 32'd0);
            bus.cmd_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        ws_q.push_back(ws);
        apb_q.push_back({w, a, d});
        if (exp_rsp) begin
            if (TO_EN && ws >= TMO) begin
                e.rdata = '0;
                e.err   = 1'b1;
                e.cyc   = cyc + 2 + (TMO - 1);
            end else begin
                e.rdata = w ? '0 : ref_mem[a];
                e.err   = 1'b0;
                e.cyc   = cyc + 2 + ws;
                if (w) ref_mem[a] = d;
            end
            exp_q.push_back(e);
        end
        $display("txn %s addr=%02h wdata=%02h waits=%0d accepted at cycle %0d",
                 w ? "WR" : "RD", a, d, ws, cyc);
    endtask

    task automatic idle_cmd();
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
    endtask

    // APB target model: a register file that holds off pready for the queued wait count.
    initial begin : apb_target
        int wait_left = 0;
        bus.pready_i = 1'b0;
        bus.prdata_i = '0;
        forever begin
            @(negedge clk);
            if (bus.psel_o && !bus.penable_o) begin
                wait_left = (ws_q.size() != 0) ? ws_q.pop_front() : 0;
                bus.pready_i = 1'($urandom);
                bus.prdata_i = DW'($urandom);
            end else if (bus.psel_o && bus.penable_o) begin
                if (wait_left > 0) begin
                    wait_left--;
                    bus.pready_i = 1'b0;
                    bus.prdata_i = DW'($urandom);
                end else begin
                    bus.pready_i = 1'b1;
                    if (bus.pwrite_o) begin
                        slave_mem[bus.paddr_o] = bus.pwdata_o;
                        bus.prdata_i = DW'($urandom);
                    end else begin
                        bus.prdata_i = slave_mem[bus.paddr_o];
                    end
                end
            end else begin
                bus.pready_i = 1'($urandom);
                bus.prdata_i = DW'($urandom);
            end
        end
    end

    // Monitor: protocol shape on the APB side and scoreboard pops on rsp_valid_o.
    initial begin : monitor
        logic        prev_psel = 1'b0;
        logic [16:0] cur = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("cmd_ready_is_idle", {31'd0, bus.cmd_ready_o}, {31'd0, !bus.psel_o});
                if (bus.psel_o && !prev_psel) begin
                    if (apb_q.size() == 0) begin
                        chk("unexpected_transfer", 32'd1, 32'd0);
                    end else begin
                        cur = apb_q.pop_front();
                        chk("setup_penable", {31'd0, bus.penable_o}, 32'd0);
                    end
                    chk("paddr", {24'd0, bus.paddr_o}, {24'd0, cur[15:8]});
                    chk("pwrite", {31'd0, bus.pwrite_o}, {31'd0, cur[16]});
                    chk("pwdata", {24'd0, bus.pwdata_o}, {24'd0, cur[7:0]});
                end else if (bus.psel_o) begin
                    chk("access_penable", {31'd0, bus.penable_o}, 32'd1);
                    chk("paddr_stable", {24'd0, bus.paddr_o}, {24'd0, cur[15:8]});
                    chk("pwrite_stable", {31'd0, bus.pwrite_o}, {31'd0, cur[16]});
                    chk("pwdata_stable", {24'd0, bus.pwdata_o}, {24'd0, cur[7:0]});
                end
                if (bus.rsp_valid_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", {24'd0, bus.rsp_rdata_o}, {24'd0, e.rdata});
                        chk("rsp_error", {31'd0, bus.rsp_error_o}, {31'd0, e.err});
                        chk("rsp_cycle", cyc, e.cyc);
                        $display("rsp rdata=%02h err=%0b at cycle %0d", bus.rsp_rdata_o,
                                 bus.rsp_error_o, cyc);
                    end
                end
                prev_psel = bus.psel_o;
            end else begin
                prev_psel = 1'b0;
            end
        end
    end

    initial begin : stimulus
        logic [DW-1:0] v;
        rst_n = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_wdata_i = '0;
        for (int i = 0; i < 256; i++) begin
            v = DW'($urandom);
            ref_mem[i]   = v;
            slave_mem[i] = v;
        end
        ref_mem[4]   = 8'hBA;
        slave_mem[4] = 8'hBA;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
        chk("rst_psel_penable", {30'd0, bus.psel_o, bus.penable_o}, 32'd0);
        chk("rst_pwrite", {31'd0, bus.pwrite_o}, 32'd0);
        chk("rst_paddr_pwdata", {16'd0, bus.paddr_o, bus.pwdata_o}, 32'd0);
        chk("rst_rsp", {22'd0, bus.rsp_valid_o, bus.rsp_error_o, bus.rsp_rdata_o}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Zero-wait write then read.
        send(1'b1, 8'h02, 8'hAB, 0, 1'b1);
        idle_cmd();
        send(1'b0, 8'h04, 8'h00, 0, 1'b1);
        idle_cmd();
        // Three wait states.
        send(1'b1, 8'h03, 8'h5C, 3, 1'b1);
        idle_cmd();
        // Back-to-back with cmd_valid_i held high.
        send(1'b1, 8'h02, 8'h11, 0, 1'b1);
        send(1'b1, 8'h04, 8'h22, 0, 1'b1);
        idle_cmd();
        send(1'b0, 8'h04, 8'h00, 0, 1'b1);
        idle_cmd();

        // Reset during ACCESS of a read: the transfer is dropped silently.
        send(1'b0, 8'h06, 8'h00, 5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_psel_penable", {30'd0, bus.psel_o, bus.penable_o}, 32'd0);
        chk("async_rst_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
        chk("async_rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        bus.cmd_valid_i = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Longest wait that still completes normally when the timeout is built in.
        send(1'b0, 8'h04, 8'h00, TMO - 1, 1'b1);
        idle_cmd();

        // Stuck target: persists without the timeout, aborts with it.
        send(1'b0, 8'h07, 8'h00, 120, 1'b1);
        idle_cmd();
`ifndef I2C_APB_MASTER_TIMEOUT_EN
        repeat (100) @(negedge clk);
        chk("access_persists", {30'd0, bus.psel_o, bus.penable_o}, 32'd3);
`else
        repeat (20) @(negedge clk);
        chk("timeout_dropped_psel", {30'd0, bus.psel_o, bus.penable_o}, 32'd0);
`endif

        for (int t = 0; t < 40; t++) begin
            send(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0, 1'b1);
            if ($urandom_range(0, 2) == 0) idle_cmd();
        end
        idle_cmd();

        for (int n = 0; n < 3000 && exp_q.size() != 0; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("drain_rsp_queue", exp_q.size(), 32'd0);
        chk("drain_apb_queue", apb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
